// File: rtl/comandos_pkg.sv
// Shared constants for the UART command link: FSM states, command codes, status codes.
// Used by escalonador_comandos and contador_timeout.
package comandos_pkg;

    localparam int unsigned LARGURA_BYTE     = 8;
    localparam int unsigned LARGURA_ENDERECO = 5;
    localparam int unsigned LARGURA_CONTADOR = 27;

    typedef enum logic [2:0] {
        ESPERA_B1  = 3'd0,
        ESPERA_B2  = 3'd1,
        VALIDA     = 3'd2,
        REQ_SENSOR = 3'd3,
        ENVIA_B1   = 3'd4,
        AGUARDA_B1 = 3'd5,
        ENVIA_B2   = 3'd6,
        AGUARDA_B2 = 3'd7
    } estado_t;

    localparam logic [LARGURA_BYTE-1:0] CMD_STATUS      = 8'h00;
    localparam logic [LARGURA_BYTE-1:0] CMD_TEMPERATURA = 8'h01;
    localparam logic [LARGURA_BYTE-1:0] CMD_UMIDADE     = 8'h02;

    localparam logic [LARGURA_BYTE-1:0] STATUS_CMD_INVALIDO = 8'hFF;
    localparam logic [LARGURA_BYTE-1:0] STATUS_END_INVALIDO = 8'hFE;
    localparam logic [LARGURA_BYTE-1:0] STATUS_ERRO_SENSOR  = 8'h1F;
    localparam logic [LARGURA_BYTE-1:0] STATUS_TIMEOUT      = 8'h1E;
    localparam logic [LARGURA_BYTE-1:0] STATUS_OK_BASE      = 8'h08;

    // Two-byte response sent back over the UART: status first, then data.
    typedef struct packed {
        logic [LARGURA_BYTE-1:0] status;
        logic [LARGURA_BYTE-1:0] dado;
    } resposta_t;

    function automatic logic comando_valido(input logic [LARGURA_BYTE-1:0] cmd);
        return (cmd == CMD_STATUS) || (cmd == CMD_TEMPERATURA) || (cmd == CMD_UMIDADE);
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Free-running timeout counter with clear priority over enable.
// o_fim_c flags the terminal count TERMINAL-1 combinationally.
module contador_timeout
    import comandos_pkg::*;
#(
    parameter int unsigned TERMINAL = 1000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_limpar,
    input  logic i_habilitar,
    output logic o_fim_c
);

    logic [LARGURA_CONTADOR-1:0] r_contagem;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_limpar) begin
            r_contagem <= '0;
        end else if (i_habilitar) begin
            r_contagem <= r_contagem + LARGURA_CONTADOR'(1);
        end
    end

    assign o_fim_c = (r_contagem == LARGURA_CONTADOR'(TERMINAL - 1));

endmodule

// File: rtl/escalonador_comandos.sv
// Sequences one UART command -> sensor request -> 2-byte UART response transaction.
// Define TIMEOUT_BYTE_EN to discard a lone first byte after CLOCKS_TIMEOUT_BYTE idle cycles.
module escalonador_comandos
    import comandos_pkg::*;
#(
    parameter int unsigned NUM_SENSORES          = 32,
`ifdef TIMEOUT_BYTE_EN
    parameter int unsigned CLOCKS_TIMEOUT_BYTE   = 50_000_000,
`endif
    parameter int unsigned CLOCKS_TIMEOUT_SENSOR = 100_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        byteRecebido,
    input  logic [LARGURA_BYTE-1:0]     dadoRecebido,
    output logic                        sensorRequisicao,
    output logic [LARGURA_BYTE-1:0]     sensorComando,
    output logic [LARGURA_ENDERECO-1:0] sensorEndereco,
    input  logic                        sensorPronto,
    input  logic                        sensorErro,
    input  logic [LARGURA_BYTE-1:0]     sensorDado,
    output logic                        txIniciar,
    output logic [LARGURA_BYTE-1:0]     txByte,
    input  logic                        txConcluido,
    output logic                        ocupado
);

    estado_t                     r_estado;
    logic [LARGURA_BYTE-1:0]     r_comando;
    logic [LARGURA_BYTE-1:0]     r_endereco;
    resposta_t                   r_resposta;
    logic                        r_sensor_requisicao;
    logic [LARGURA_BYTE-1:0]     r_sensor_comando;
    logic [LARGURA_ENDERECO-1:0] r_sensor_endereco;
    logic                        r_tx_iniciar;
    logic [LARGURA_BYTE-1:0]     r_tx_byte;
    logic                        r_ocupado;

    // Counters run only inside their state, so leaving/entering a state clears them.
    logic w_conta_sensor;
    logic w_fim_sensor;

    assign w_conta_sensor = (r_estado == REQ_SENSOR);

    contador_timeout #(
        .TERMINAL (CLOCKS_TIMEOUT_SENSOR)
    ) u_timeout_sensor (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_limpar    (!w_conta_sensor),
        .i_habilitar (w_conta_sensor),
        .o_fim_c     (w_fim_sensor)
    );

`ifdef TIMEOUT_BYTE_EN
    logic w_conta_byte;
    logic w_fim_byte;

    assign w_conta_byte = (r_estado == ESPERA_B2);

    contador_timeout #(
        .TERMINAL (CLOCKS_TIMEOUT_BYTE)
    ) u_timeout_byte (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_limpar    (!w_conta_byte),
        .i_habilitar (w_conta_byte),
        .o_fim_c     (w_fim_byte)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado            <= ESPERA_B1;
            r_comando           <= '0;
            r_endereco          <= '0;
            r_resposta          <= '0;
            r_sensor_requisicao <= 1'b0;
            r_sensor_comando    <= '0;
            r_sensor_endereco   <= '0;
            r_tx_iniciar        <= 1'b0;
            r_tx_byte           <= '0;
            r_ocupado           <= 1'b0;
        end else begin
            r_tx_iniciar <= 1'b0;
            case (r_estado)
                ESPERA_B1: begin
                    if (byteRecebido) begin
                        r_comando <= dadoRecebido;
                        r_ocupado <= 1'b1;
                        r_estado  <= ESPERA_B2;
                    end
                end
                ESPERA_B2: begin
                    if (byteRecebido) begin
                        r_endereco <= dadoRecebido;
                        r_estado   <= VALIDA;
                    end
`ifdef TIMEOUT_BYTE_EN
                    else if (w_fim_byte) begin
                        r_comando <= '0;
                        r_ocupado <= 1'b0;
                        r_estado  <= ESPERA_B1;
                    end
`endif
                end
                VALIDA: begin
                    if (!comando_valido(r_comando)) begin
                        r_resposta   <= '{status: STATUS_CMD_INVALIDO, dado: 8'h00};
                        r_tx_byte    <= STATUS_CMD_INVALIDO;
                        r_tx_iniciar <= 1'b1;
                        r_estado     <= ENVIA_B1;
                    end else if (32'(r_endereco) >= NUM_SENSORES) begin
                        r_resposta   <= '{status: STATUS_END_INVALIDO, dado: 8'h00};
                        r_tx_byte    <= STATUS_END_INVALIDO;
                        r_tx_iniciar <= 1'b1;
                        r_estado     <= ENVIA_B1;
                    end else begin
                        r_sensor_requisicao <= 1'b1;
                        r_sensor_comando    <= r_comando;
                        r_sensor_endereco   <= r_endereco[LARGURA_ENDERECO-1:0];
                        r_estado            <= REQ_SENSOR;
                    end
                end
                // sensorPronto is checked first so it wins over a same-cycle timeout.
                REQ_SENSOR: begin
                    if (sensorPronto) begin
                        r_sensor_requisicao <= 1'b0;
                        r_tx_iniciar        <= 1'b1;
                        r_estado            <= ENVIA_B1;
                        if (sensorErro) begin
                            r_resposta <= '{status: STATUS_ERRO_SENSOR, dado: 8'h00};
                            r_tx_byte  <= STATUS_ERRO_SENSOR;
                        end else begin
                            r_resposta <= '{status: STATUS_OK_BASE | r_comando, dado: sensorDado};
                            r_tx_byte  <= STATUS_OK_BASE | r_comando;
                        end
                    end else if (w_fim_sensor) begin
                        r_sensor_requisicao <= 1'b0;
                        r_resposta          <= '{status: STATUS_TIMEOUT, dado: 8'h00};
                        r_tx_byte           <= STATUS_TIMEOUT;
                        r_tx_iniciar        <= 1'b1;
                        r_estado            <= ENVIA_B1;
                    end
                end
                ENVIA_B1: begin
                    r_estado <= AGUARDA_B1;
                end
                AGUARDA_B1: begin
                    if (txConcluido) begin
                        r_tx_byte    <= r_resposta.dado;
                        r_tx_iniciar <= 1'b1;
                        r_estado     <= ENVIA_B2;
                    end
                end
                ENVIA_B2: begin
                    r_estado <= AGUARDA_B2;
                end
                AGUARDA_B2: begin
                    if (txConcluido) begin
                        r_ocupado <= 1'b0;
                        r_estado  <= ESPERA_B1;
                    end
                end
                default: begin
                    r_sensor_requisicao <= 1'b0;
                    r_ocupado           <= 1'b0;
                    r_estado            <= ESPERA_B1;
                end
            endcase
        end
    end

    assign sensorRequisicao = r_sensor_requisicao;
    assign sensorComando    = r_sensor_comando;
    assign sensorEndereco   = r_sensor_endereco;
    assign txIniciar        = r_tx_iniciar;
    assign txByte           = r_tx_byte;
    assign ocupado          = r_ocupado;

endmodule

// File: tb/tb_escalonador_comandos.sv
// Scoreboard bench for escalonador_comandos: stimulus pushes expected sensor requests and
// tx bytes into queues, monitors pop and compare. Define TIMEOUT_BYTE_EN for the byte-gap case.
module tb_escalonador_comandos;

    typedef struct {
        logic [7:0] cmd;
        logic [4:0] ender;
        int         dur;
    } req_esp_t;

    logic       clock;
    logic       reset;
    logic       byteRecebido;
    logic [7:0] dadoRecebido;
    logic       sensorRequisicao;
    logic [7:0] sensorComando;
    logic [4:0] sensorEndereco;
    logic       sensorPronto;
    logic       sensorErro;
    logic [7:0] sensorDado;
    logic       txIniciar;
    logic [7:0] txByte;
    logic       txConcluido;
    logic       ocupado;

    int n_testes = 0;
    int n_falhas = 0;

    logic [7:0] fila_tx[$];
    req_esp_t   fila_req[$];

    // Sensor model configuration
    int         s_atraso = 10;
    logic       s_erro   = 1'b0;
    logic [7:0] s_dado   = 8'h00;
    logic       s_mudo   = 1'b0;
    int         s_cnt    = 0;

    // uart_tx model
    logic tx_auto   = 1'b1;
    int   tx_atraso = 0;
    time  t_concl   = 0;

    // Request monitor state
    logic     req_ant = 1'b0;
    int       req_dur = 0;
    req_esp_t req_frente;

    escalonador_comandos #(
        .NUM_SENSORES          (32),
`ifdef TIMEOUT_BYTE_EN
        .CLOCKS_TIMEOUT_BYTE   (500),
`endif
        .CLOCKS_TIMEOUT_SENSOR (1000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .byteRecebido     (byteRecebido),
        .dadoRecebido     (dadoRecebido),
        .sensorRequisicao (sensorRequisicao),
        .sensorComando    (sensorComando),
        .sensorEndereco   (sensorEndereco),
        .sensorPronto     (sensorPronto),
        .sensorErro       (sensorErro),
        .sensorDado       (sensorDado),
        .txIniciar        (txIniciar),
        .txByte           (txByte),
        .txConcluido      (txConcluido),
        .ocupado          (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verificar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_testes++;
        if (atual !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
        end
    endtask

    task automatic falha(input string nome);
        n_testes++;
        n_falhas++;
        $display("FAIL %s: event missing or unexpected", nome);
    endtask

    // Sensor model: answers sensor_atraso cycles after the request rises.
    always @(negedge clock) begin
        sensorPronto = 1'b0;
        sensorErro   = 1'b0;
        sensorDado   = 8'h00;
        if (sensorRequisicao) begin
            s_cnt++;
            if (!s_mudo && s_cnt == s_atraso) begin
                sensorPronto = 1'b1;
                sensorErro   = s_erro;
                sensorDado   = s_dado;
            end
        end else begin
            s_cnt = 0;
        end
    end

    // uart_tx model: txConcluido six cycles after each txIniciar.
    always @(negedge clock) begin
        txConcluido = 1'b0;
        if (tx_atraso > 0) begin
            tx_atraso--;
            if (tx_atraso == 0 && tx_auto) begin
                txConcluido = 1'b1;
                t_concl     = $time;
            end
        end
        if (txIniciar) tx_atraso = 6;
    end

    // Monitor: tx bytes against the expected queue.
    always @(negedge clock) begin
        if (txIniciar) begin
            if (fila_tx.size() == 0) falha("tx_unexpected");
            else verificar("tx_byte", 32'(txByte), 32'(fila_tx.pop_front()));
        end
    end

    // Monitor: sensor request command/address and high-time.
    always @(negedge clock) begin
        if (sensorRequisicao && !req_ant) begin
            req_dur = 1;
            if (fila_req.size() == 0) begin
                falha("req_unexpected");
            end else begin
                req_frente = fila_req[0];
                verificar("req_cmd", 32'(sensorComando), 32'(req_frente.cmd));
                verificar("req_addr", 32'(sensorEndereco), 32'(req_frente.ender));
            end
        end else if (sensorRequisicao) begin
            req_dur++;
        end else if (req_ant && fila_req.size() != 0) begin
            req_frente = fila_req.pop_front();
            verificar("req_duration", 32'(req_dur), 32'(req_frente.dur));
        end
        req_ant = sensorRequisicao;
    end

    task automatic enviar_byte(input logic [7:0] b);
        @(negedge clock);
        byteRecebido = 1'b1;
        dadoRecebido = b;
        @(negedge clock);
        byteRecebido = 1'b0;
        dadoRecebido = 8'h00;
    endtask

    task automatic esperar_fim(input string nome);
        int c = 0;
        while (ocupado && c < 20000) begin
            @(negedge clock);
            c++;
        end
        if (ocupado) begin
            falha({nome, "_idle_timeout"});
        end else begin
            verificar({nome, "_tx_pending"}, 32'(fila_tx.size()), 0);
            verificar({nome, "_busy_fall"}, 32'($time - t_concl), 10);
        end
        repeat (5) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        falha("watchdog");
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        reset        = 1'b1;
        byteRecebido = 1'b0;
        dadoRecebido = 8'h00;
        sensorPronto = 1'b0;
        sensorErro   = 1'b0;
        sensorDado   = 8'h00;
        txConcluido  = 1'b0;
        repeat (3) @(negedge clock);
        verificar("rst_req", 32'(sensorRequisicao), 0);
        verificar("rst_cmd", 32'(sensorComando), 0);
        verificar("rst_addr", 32'(sensorEndereco), 0);
        verificar("rst_txini", 32'(txIniciar), 0);
        verificar("rst_txbyte", 32'(txByte), 0);
        verificar("rst_busy", 32'(ocupado), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Temperature from sensor 3, answer after 100 cycles; stray byte while busy is ignored.
        s_atraso = 100; s_erro = 1'b0; s_dado = 8'h19; s_mudo = 1'b0;
        fila_req.push_back('{cmd: 8'h01, ender: 5'd3, dur: 100});
        fila_tx.push_back(8'h09);
        fila_tx.push_back(8'h19);
        enviar_byte(8'h01);
        enviar_byte(8'h03);
        verificar("t1_busy", 32'(ocupado), 1);
        repeat (20) @(negedge clock);
        enviar_byte(8'h02);
        esperar_fim("t1");

        // Invalid command: no request, FF/00, txIniciar two cycles after byte 2.
        fila_tx.push_back(8'hFF);
        fila_tx.push_back(8'h00);
        enviar_byte(8'h07);
        enviar_byte(8'h05);
        @(negedge clock);
        verificar("t2_latency", 32'(txIniciar), 1);
        esperar_fim("t2");

        // Address 0x20 is one past the last sensor.
        fila_tx.push_back(8'hFE);
        fila_tx.push_back(8'h00);
        enviar_byte(8'h01);
        enviar_byte(8'h20);
        esperar_fim("t3");

        // Silent sensor at the last valid address: timeout after 1000 cycles.
        s_mudo = 1'b1;
        fila_req.push_back('{cmd: 8'h02, ender: 5'd31, dur: 1000});
        fila_tx.push_back(8'h1E);
        fila_tx.push_back(8'h00);
        enviar_byte(8'h02);
        enviar_byte(8'h1F);
        esperar_fim("t4");
        s_mudo = 1'b0;

        // Sensor error, then reset while waiting for the first txConcluido.
        s_atraso = 10; s_erro = 1'b1; s_dado = 8'h55;
        tx_auto = 1'b0;
        fila_req.push_back('{cmd: 8'h01, ender: 5'd7, dur: 10});
        fila_tx.push_back(8'h1F);
        enviar_byte(8'h01);
        enviar_byte(8'h07);
        c = 0;
        while (!txIniciar && c < 200) begin
            @(negedge clock);
            c++;
        end
        if (!txIniciar) falha("t5_tx_missing");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        verificar("t5_req", 32'(sensorRequisicao), 0);
        verificar("t5_cmd", 32'(sensorComando), 0);
        verificar("t5_addr", 32'(sensorEndereco), 0);
        verificar("t5_txini", 32'(txIniciar), 0);
        verificar("t5_txbyte", 32'(txByte), 0);
        verificar("t5_busy", 32'(ocupado), 0);
        tx_auto = 1'b1;
        repeat (50) @(negedge clock);
        verificar("t5_tx_pending", 32'(fila_tx.size()), 0);
        s_erro = 1'b0;

        // Status command on sensor 0 after the aborted transaction.
        s_atraso = 3; s_dado = 8'hA5;
        fila_req.push_back('{cmd: 8'h00, ender: 5'd0, dur: 3});
        fila_tx.push_back(8'h08);
        fila_tx.push_back(8'hA5);
        enviar_byte(8'h00);
        enviar_byte(8'h00);
        esperar_fim("t6");

`ifdef TIMEOUT_BYTE_EN
        // Lone first byte is discarded after 500 idle cycles.
        s_atraso = 5; s_dado = 8'h33;
        enviar_byte(8'h01);
        repeat (600) @(negedge clock);
        verificar("t7_discarded", 32'(ocupado), 0);
        fila_req.push_back('{cmd: 8'h02, ender: 5'd0, dur: 5});
        fila_tx.push_back(8'h0A);
        fila_tx.push_back(8'h33);
        enviar_byte(8'h02);
        enviar_byte(8'h00);
        esperar_fim("t7");
`endif

        verificar("req_pending", 32'(fila_req.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
